// File: rtl/pipe_run_checker.sv
// Run-control and register-file self-check beside the pipelined core.
// Latency: stops exactly max_cycles RUN cycles (or on a PC match), drains DRAIN_CYCLES, then 1 cycle per empty entry / 2 per checked entry.
// Backpressure: none; start/table writes are ignored while busy, and results hold in DONE until the next start or rst.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_start               one-cycle start pulse, honoured in IDLE/DONE only
//   i_max_cycles          cycle budget sampled on start (0 = unlimited)
//   i_halt_pc_en/_pc      PC-match stop enable and address, sampled on start
//   i_pc                  core program counter
//   i_exp_wr_*            expectation-table write (index, register, value)
//   i_exp_clr             invalidate the whole table
//   o_cpu_run             core run-enable (RUN and DRAIN)
//   o_rf_rd_addr/i_rf_rd_data  debug read port, data valid one cycle after address
//   o_busy/o_done/o_pass  status
//   o_fail_count, o_first_fail_idx, o_first_fail_data  check results
//   o_cycle_count         RUN cycles elapsed (saturating)
//   o_halt_cause          {pc_match, budget}
module pipe_run_checker #(
  parameter  int DATA_W       = 32,
  parameter  int REG_AW       = 5,
  parameter  int NUM_CHECKS   = 8,
  parameter  int CYC_W        = 32,
  parameter  int DRAIN_CYCLES = 5,
  localparam int IDX_W        = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1,
  localparam int FC_W         = $clog2(NUM_CHECKS + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [CYC_W-1:0]  i_max_cycles,
  input  logic              i_halt_pc_en,
  input  logic [DATA_W-1:0] i_halt_pc,
  input  logic [DATA_W-1:0] i_pc,
  input  logic              i_exp_wr_en,
  input  logic [IDX_W-1:0]  i_exp_wr_idx,
  input  logic [REG_AW-1:0] i_exp_wr_reg,
  input  logic [DATA_W-1:0] i_exp_wr_val,
  input  logic              i_exp_clr,
  output logic              o_cpu_run,
  output logic [REG_AW-1:0] o_rf_rd_addr,
  input  logic [DATA_W-1:0] i_rf_rd_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_pass,
  output logic [FC_W-1:0]   o_fail_count,
  output logic [IDX_W-1:0]  o_first_fail_idx,
  output logic [DATA_W-1:0] o_first_fail_data,
  output logic [CYC_W-1:0]  o_cycle_count,
  output logic [1:0]        o_halt_cause
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_DRAIN = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int                DRN_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRN_W-1:0]  DRN_LAST = DRN_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_CHECKS - 1);
  localparam logic [IDX_W:0]    NUM_ENT  = (IDX_W + 1)'(NUM_CHECKS);

  // FSM
  state_t r_state;
  state_t w_state_nxt;

  // Configuration sampled on start
  logic [CYC_W-1:0]  r_max_cycles;
  logic              r_halt_pc_en;
  logic [DATA_W-1:0] r_halt_pc;

  // Run / drain / check progress
  logic [CYC_W-1:0]  r_cycle_count;
  logic [DRN_W-1:0]  r_drain_cnt;
  logic [IDX_W-1:0]  r_idx;
  logic              r_phase;        // 0: look at entry / issue read, 1: compare read data
  logic [REG_AW-1:0] r_rf_rd_addr;

  // Results
  logic [FC_W-1:0]   r_fail_count;
  logic [IDX_W-1:0]  r_first_fail_idx;
  logic [DATA_W-1:0] r_first_fail_data;
  logic [1:0]        r_halt_cause;

  // Expectation table
  logic [NUM_CHECKS-1:0] r_exp_vld;
  logic [REG_AW-1:0]     r_exp_reg [NUM_CHECKS];
  logic [DATA_W-1:0]     r_exp_val [NUM_CHECKS];

  // Combinational helpers
  logic w_cfg_ok;
  logic w_wr_ok;
  logic w_stop_budget;
  logic w_stop_pc;
  logic w_stop;
  logic w_ent_vld;
  logic w_ent_last;
  logic w_mismatch;
  logic w_cpu_run;
  logic w_busy;
  logic w_done;
  logic w_rd_issue;

  assign w_cfg_ok = (r_state == S_IDLE) || (r_state == S_DONE);

  // clr wins over a same-cycle write; out-of-range indices are dropped.
  assign w_wr_ok = w_cfg_ok && !i_exp_clr && i_exp_wr_en &&
                   ({1'b0, i_exp_wr_idx} < NUM_ENT);

  // Budget compares against the post-increment count so the run lasts exactly
  // max_cycles RUN cycles.
  assign w_stop_budget = (r_max_cycles != '0) &&
                         ((r_cycle_count + CYC_W'(1)) == r_max_cycles);
  assign w_stop_pc     = r_halt_pc_en && (i_pc == r_halt_pc);
  assign w_stop        = (r_state == S_RUN) && (w_stop_budget || w_stop_pc);

  assign w_ent_vld  = r_exp_vld[r_idx];
  assign w_ent_last = (r_idx == IDX_LAST);
  assign w_mismatch = (i_rf_rd_data != r_exp_val[r_idx]);

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state and state-decoded outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cpu_run   = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    w_rd_issue  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_cpu_run = 1'b1;
        w_busy    = 1'b1;
        if (w_stop) begin
          w_state_nxt = (DRAIN_CYCLES == 0) ? S_CHECK : S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_cpu_run = 1'b1;
        w_busy    = 1'b1;
        if (r_drain_cnt == DRN_LAST) begin
          w_state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        w_busy     = 1'b1;
        w_rd_issue = !r_phase && w_ent_vld;
        // Leave after the compare of the last entry, or after skipping it.
        if ((r_phase || !w_ent_vld) && w_ent_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_done = 1'b1;
        if (i_start) begin
          w_state_nxt = S_RUN;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Run counters, check walk and result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_max_cycles      <= '0;
      r_halt_pc_en      <= 1'b0;
      r_halt_pc         <= '0;
      r_cycle_count     <= '0;
      r_drain_cnt       <= '0;
      r_idx             <= '0;
      r_phase           <= 1'b0;
      r_rf_rd_addr      <= '0;
      r_fail_count      <= '0;
      r_first_fail_idx  <= '0;
      r_first_fail_data <= '0;
      r_halt_cause      <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_max_cycles      <= i_max_cycles;
            r_halt_pc_en      <= i_halt_pc_en;
            r_halt_pc         <= i_halt_pc;
            r_cycle_count     <= '0;
            r_drain_cnt       <= '0;
            r_idx             <= '0;
            r_phase           <= 1'b0;
            r_fail_count      <= '0;
            r_first_fail_idx  <= '0;
            r_first_fail_data <= '0;
            r_halt_cause      <= 2'b00;
          end
        end
        S_RUN: begin
          if (r_cycle_count != '1) begin
            r_cycle_count <= r_cycle_count + CYC_W'(1);
          end
          if (w_stop) begin
            r_halt_cause <= {w_stop_pc, w_stop_budget};
            r_drain_cnt  <= '0;
          end
        end
        S_DRAIN: begin
          r_drain_cnt <= r_drain_cnt + DRN_W'(1);
        end
        S_CHECK: begin
          if (!r_phase) begin
            if (w_ent_vld) begin
              // Address goes out combinationally this cycle; keep a copy so the
              // port holds it once the walk moves on.
              r_phase      <= 1'b1;
              r_rf_rd_addr <= r_exp_reg[r_idx];
            end else if (!w_ent_last) begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end else begin
            r_phase <= 1'b0;
            if (w_mismatch) begin
              r_fail_count <= r_fail_count + FC_W'(1);
              if (r_fail_count == '0) begin
                r_first_fail_idx  <= r_idx;
                r_first_fail_data <= i_rf_rd_data;
              end
            end
            if (!w_ent_last) begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Expectation table: valid bits are reset, payload is not
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_exp_vld <= '0;
    end else if (w_cfg_ok && i_exp_clr) begin
      r_exp_vld <= '0;
    end else if (w_wr_ok) begin
      r_exp_vld[i_exp_wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst && w_wr_ok) begin
      r_exp_reg[i_exp_wr_idx] <= i_exp_wr_reg;
      r_exp_val[i_exp_wr_idx] <= i_exp_wr_val;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_cpu_run         = w_cpu_run;
  assign o_busy            = w_busy;
  assign o_done            = w_done;
  assign o_pass            = w_done && (r_fail_count == '0);
  assign o_rf_rd_addr      = w_rd_issue ? r_exp_reg[r_idx] : r_rf_rd_addr;
  assign o_fail_count      = r_fail_count;
  assign o_first_fail_idx  = r_first_fail_idx;
  assign o_first_fail_data = r_first_fail_data;
  assign o_cycle_count     = r_cycle_count;
  assign o_halt_cause      = r_halt_cause;

endmodule

// File: tb/tb_pipe_run_checker.sv
module tb_pipe_run_checker;
  localparam int DATA_W       = 32;
  localparam int REG_AW       = 5;
  localparam int NUM_CHECKS   = 8;
  localparam int CYC_W        = 32;
  localparam int DRAIN_CYCLES = 5;
  localparam int IDX_W        = 3;
  localparam int FC_W         = 4;
  localparam longint BIG      = 64'h7FFF_FFFF_FFFF_FFFF;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [CYC_W-1:0]  max_cycles;
  logic              halt_pc_en;
  logic [DATA_W-1:0] halt_pc;
  logic [DATA_W-1:0] pc;
  logic              exp_wr_en;
  logic [IDX_W-1:0]  exp_wr_idx;
  logic [REG_AW-1:0] exp_wr_reg;
  logic [DATA_W-1:0] exp_wr_val;
  logic              exp_clr;
  logic              cpu_run;
  logic [REG_AW-1:0] rf_rd_addr;
  logic [DATA_W-1:0] rf_rd_data;
  logic              busy;
  logic              done;
  logic              pass;
  logic [FC_W-1:0]   fail_count;
  logic [IDX_W-1:0]  first_fail_idx;
  logic [DATA_W-1:0] first_fail_data;
  logic [CYC_W-1:0]  cycle_count;
  logic [1:0]        halt_cause;

  always #5 clk = ~clk;

  pipe_run_checker #(
    .DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_CHECKS(NUM_CHECKS),
    .CYC_W(CYC_W), .DRAIN_CYCLES(DRAIN_CYCLES)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .i_max_cycles(max_cycles), .i_halt_pc_en(halt_pc_en), .i_halt_pc(halt_pc),
    .i_pc(pc),
    .i_exp_wr_en(exp_wr_en), .i_exp_wr_idx(exp_wr_idx), .i_exp_wr_reg(exp_wr_reg),
    .i_exp_wr_val(exp_wr_val), .i_exp_clr(exp_clr),
    .o_cpu_run(cpu_run), .o_rf_rd_addr(rf_rd_addr), .i_rf_rd_data(rf_rd_data),
    .o_busy(busy), .o_done(done), .o_pass(pass), .o_fail_count(fail_count),
    .o_first_fail_idx(first_fail_idx), .o_first_fail_data(first_fail_data),
    .o_cycle_count(cycle_count), .o_halt_cause(halt_cause)
  );

  // Register-file model: synchronous read, data one cycle after the address.
  logic [DATA_W-1:0] rf_mem [32];
  always_ff @(posedge clk) rf_rd_data <= rf_mem[rf_rd_addr];

  // Core PC model: advances by 4 per RUN cycle from pc_base.
  logic [DATA_W-1:0] pc_base;
  always_comb pc = pc_base + (cycle_count << 2);

  // Reference table contents
  bit                m_vld [NUM_CHECKS];
  logic [REG_AW-1:0] m_reg [NUM_CHECKS];
  logic [DATA_W-1:0] m_val [NUM_CHECKS];

  typedef struct {
    logic [CYC_W-1:0]  cyc;
    logic [1:0]        cause;
    logic [FC_W-1:0]   fails;
    logic [IDX_W-1:0]  ffi;
    logic [DATA_W-1:0] ffd;
    logic              pass;
    int                run_cyc;
    int                chk_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // Expected outcome of one run, from the stop rules and the table contents.
  function automatic exp_t model(input logic [CYC_W-1:0] mx, input logic en,
                                 input logic [DATA_W-1:0] hpc);
    exp_t e;
    longint kb, kp, k;
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] got;
    kb = (mx != 0) ? longint'({32'd0, mx}) : BIG;
    d  = hpc - pc_base;
    kp = (en && d[1:0] == 2'b00) ? longint'({32'd0, d >> 2}) + 1 : BIG;
    k  = (kb < kp) ? kb : kp;
    e.cyc     = k[CYC_W-1:0];
    e.cause   = {kp == k, kb == k};
    e.run_cyc = int'(k) + DRAIN_CYCLES;
    e.fails   = '0;
    e.ffi     = '0;
    e.ffd     = '0;
    e.chk_cyc = 0;
    for (int i = 0; i < NUM_CHECKS; i++) begin
      if (m_vld[i]) begin
        e.chk_cyc += 2;
        got = rf_mem[m_reg[i]];
        if (got != m_val[i]) begin
          if (e.fails == 0) begin
            e.ffi = IDX_W'(i);
            e.ffd = got;
          end
          e.fails = e.fails + 1'b1;
        end
      end else begin
        e.chk_cyc += 1;
      end
    end
    e.pass = (e.fails == 0);
    return e;
  endfunction

  // Monitor: on each rising done, pop the oldest expectation and compare.
  initial begin : monitor
    logic prev_busy;
    logic prev_done;
    int   run_cyc;
    int   chk_cyc;
    exp_t e;
    prev_busy = 1'b0;
    prev_done = 1'b0;
    run_cyc   = 0;
    chk_cyc   = 0;
    forever begin
      @(negedge clk);
      if (busy === 1'b1 && prev_busy !== 1'b1) begin
        run_cyc = 0;
        chk_cyc = 0;
      end
      if (cpu_run === 1'b1) run_cyc++;
      if (busy === 1'b1 && cpu_run !== 1'b1) chk_cyc++;
      if (done === 1'b1 && prev_done !== 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_done: done rose with no pending run");
        end else begin
          e = exp_q.pop_front();
          chk("cycle_count",     cycle_count,     e.cyc);
          chk("halt_cause",      halt_cause,      e.cause);
          chk("fail_count",      fail_count,      e.fails);
          chk("first_fail_idx",  first_fail_idx,  e.ffi);
          chk("first_fail_data", first_fail_data, e.ffd);
          chk("pass",            pass,            e.pass);
          chk("cpu_run_cycles",  run_cyc,         e.run_cyc);
          chk("check_cycles",    chk_cyc,         e.chk_cyc);
        end
      end
      prev_busy = busy;
      prev_done = done;
    end
  end

  task automatic wr(input int idx, input logic [REG_AW-1:0] r, input logic [DATA_W-1:0] v);
    exp_wr_en  = 1'b1;
    exp_wr_idx = IDX_W'(idx);
    exp_wr_reg = r;
    exp_wr_val = v;
    @(negedge clk);
    exp_wr_en  = 1'b0;
    m_vld[idx] = 1'b1;
    m_reg[idx] = r;
    m_val[idx] = v;
  endtask

  task automatic clr();
    exp_clr = 1'b1;
    @(negedge clk);
    exp_clr = 1'b0;
    for (int i = 0; i < NUM_CHECKS; i++) m_vld[i] = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_timeout: done=%b after %0d cycles, required 1", nm, done, n);
    end
  endtask

  task automatic run(input string nm, input logic [CYC_W-1:0] mx, input logic en,
                     input logic [DATA_W-1:0] hpc);
    max_cycles = mx;
    halt_pc_en = en;
    halt_pc    = hpc;
    exp_q.push_back(model(mx, en, hpc));
    pulse_start();
    wait_done(nm);
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_busy"},    busy,            1'b0);
    chk({nm, "_done"},    done,            1'b0);
    chk({nm, "_pass"},    pass,            1'b0);
    chk({nm, "_cpu_run"}, cpu_run,         1'b0);
    chk({nm, "_rd_addr"}, rf_rd_addr,      '0);
    chk({nm, "_fails"},   fail_count,      '0);
    chk({nm, "_ffi"},     first_fail_idx,  '0);
    chk({nm, "_ffd"},     first_fail_data, '0);
    chk({nm, "_cycles"},  cycle_count,     '0);
    chk({nm, "_cause"},   halt_cause,      2'b00);
  endtask

  initial begin : stim
    logic [CYC_W-1:0]  mx;
    logic              en;
    logic [DATA_W-1:0] hpc;
    logic [REG_AW-1:0] r;
    logic [DATA_W-1:0] v;
    rst        = 1'b1;
    start      = 1'b0;
    max_cycles = '0;
    halt_pc_en = 1'b0;
    halt_pc    = '0;
    exp_wr_en  = 1'b0;
    exp_wr_idx = '0;
    exp_wr_reg = '0;
    exp_wr_val = '0;
    exp_clr    = 1'b0;
    pc_base    = 32'd1000;
    for (int i = 0; i < 32; i++) rf_mem[i] = $urandom;
    for (int i = 0; i < NUM_CHECKS; i++) m_vld[i] = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle("reset");
    rst = 1'b0;
    @(negedge clk);

    // Budget stop with the reference table; all entries match.
    rf_mem[19] = 32'd5;  rf_mem[20] = 32'd10; rf_mem[21] = 32'd3;
    rf_mem[22] = 32'd2;  rf_mem[23] = 32'd15; rf_mem[24] = 32'hFFFF_FFFE;
    wr(0, 5'd19, 32'd5);
    wr(1, 5'd20, 32'd10);
    wr(2, 5'd21, 32'd3);
    wr(3, 5'd22, 32'd2);
    wr(4, 5'd23, 32'd15);
    wr(5, 5'd24, 32'hFFFF_FFFE);
    run("budget", 32'd10, 1'b0, 32'd0);

    // PC stop: pc = 176 + 4*(cycle-1) reaches 200 on RUN cycle 7.
    pc_base = 32'd176;
    run("pcstop", 32'd0, 1'b1, 32'd200);

    // Budget and PC match on the same cycle (cycle 9).
    run("both", 32'd9, 1'b1, 32'd176 + 32'd32);

    // Two mismatches: reg 21 reads 4, reg 24 reads 2.
    rf_mem[21] = 32'd4;
    rf_mem[24] = 32'd2;
    run("mismatch", 32'd10, 1'b0, 32'd0);
    rf_mem[21] = 32'd3;
    rf_mem[24] = 32'hFFFF_FFFE;

    // Held start, table write, table clear and start pulses during RUN are ignored.
    max_cycles = 32'd12;
    halt_pc_en = 1'b0;
    halt_pc    = '0;
    exp_q.push_back(model(32'd12, 1'b0, 32'd0));
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    exp_wr_en = 1'b1; exp_wr_idx = 3'd2; exp_wr_reg = 5'd21; exp_wr_val = 32'd99;
    @(negedge clk);
    exp_wr_en = 1'b0;
    exp_clr = 1'b1;
    @(negedge clk);
    exp_clr = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignored");

    // Empty table, then a sparse table with only idx 5.
    clr();
    run("empty", 32'd3, 1'b0, 32'd0);
    wr(5, 5'd7, rf_mem[7]);
    run("sparse", 32'd2, 1'b0, 32'd0);

    // Reset in the middle of DRAIN.
    wr(0, 5'd19, 32'd5);
    wr(3, 5'd22, 32'd7);
    max_cycles = 32'd4;
    halt_pc_en = 1'b0;
    pulse_start();
    repeat (5) @(negedge clk);
    chk("drain_cpu_run", cpu_run, 1'b1);
    chk("drain_cycles", cycle_count, 32'd4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_idle("mid_drain_rst");
    for (int i = 0; i < NUM_CHECKS; i++) m_vld[i] = 1'b0;
    run("after_rst", 32'd2, 1'b0, 32'd0);

    // Unlimited run keeps going until reset.
    max_cycles = 32'd0;
    halt_pc_en = 1'b0;
    pulse_start();
    repeat (40) @(negedge clk);
    chk("unlimited_cycles", cycle_count, 32'd40);
    chk("unlimited_cpu_run", cpu_run, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_idle("unlimited_rst");

    // Randomized runs against the reference model.
    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < 32; i++) rf_mem[i] = $urandom;
      pc_base = $urandom & 32'hFFFF_FFFC;
      clr();
      for (int i = 0; i < NUM_CHECKS; i++) begin
        if ($urandom_range(1, 0) == 1) begin
          r = REG_AW'($urandom_range(31, 0));
          v = rf_mem[r];
          if ($urandom_range(3, 0) == 0) v = v ^ (32'h1 << $urandom_range(31, 0));
          wr(i, r, v);
        end
      end
      case ($urandom_range(2, 0))
        0: begin
          mx = CYC_W'($urandom_range(20, 1)); en = 1'b0; hpc = '0;
        end
        1: begin
          mx = '0; en = 1'b1; hpc = pc_base + 32'($urandom_range(19, 0)) * 4;
        end
        default: begin
          mx = CYC_W'($urandom_range(20, 1)); en = 1'b1;
          hpc = pc_base + 32'($urandom_range(19, 0)) * 4 + (($urandom_range(3, 0) == 0) ? 32'd2 : 32'd0);
        end
      endcase
      run("random", mx, en, hpc);
    end

    repeat (5) @(negedge clk);
    chk("pending_runs", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_run_checker.md
Name: pipe_run_checker

Overview:
- Parametrised, synthesizable run-control and self-check block for the pipelined processor.
- Starts the core and stops it after a programmed cycle budget or when PC reaches a halt address.
- Waits for the pipeline to drain, then reads back up to NUM_CHECKS register-file entries and compares each against a loaded expected value.
- Sits beside Top_pipline. It drives the core run-enable and a register-file debug read port, and reports pass/fail, the first failing entry and cycle statistics.

Parameters:
- DATA_W, 32, register/PC width.
- REG_AW, 5, register-file address width.
- NUM_CHECKS, 8, expectation-table entries.
- CYC_W, 32, cycle counter width.
- DRAIN_CYCLES, 5, cycles run after the stop condition so in-flight instructions reach writeback.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse; honoured only in IDLE or DONE.
- max_cycles  in  CYC_W  cycle budget; sampled on start; 0 means unlimited.
- halt_pc_en  in  1  enable PC-match stop; sampled on start.
- halt_pc  in  DATA_W  stop address; sampled on start.
- pc  in  DATA_W  current core program counter.
- exp_wr_en  in  1  write one expectation entry; ignored outside IDLE/DONE.
- exp_wr_idx  in  clog2(NUM_CHECKS)  entry index.
- exp_wr_reg  in  REG_AW  register number to check.
- exp_wr_val  in  DATA_W  expected value.
- exp_clr  in  1  invalidate all entries; ignored outside IDLE/DONE.
- cpu_run  out  1  core run-enable.
- rf_rd_addr  out  REG_AW  debug read address.
- rf_rd_data  in  DATA_W  debug read data, valid the cycle after the address.
- busy  out  1  high in RUN, DRAIN, CHECK.
- done  out  1  high in DONE.
- pass  out  1  done and fail_count==0.
- fail_count  out  clog2(NUM_CHECKS+1)  number of mismatching entries.
- first_fail_idx  out  clog2(NUM_CHECKS)  index of the first mismatch; 0 if none.
- first_fail_data  out  DATA_W  value actually read for first_fail_idx.
- cycle_count  out  CYC_W  RUN cycles elapsed.
- halt_cause  out  2  00 none, 01 budget, 10 PC match, 11 both in the same cycle.

Behaviour:
- Reset values:
  - State IDLE.
  - All outputs 0.
  - All table valid bits cleared.
  - Sampled config cleared.
  - Reset has priority over every other input and aborts any state; cpu_run drops the next edge.
- States: IDLE, RUN, DRAIN, CHECK, DONE.
- IDLE/DONE + start:
  - Sample max_cycles, halt_pc_en, halt_pc.
  - Clear cycle_count, fail_count, first_fail_*, halt_cause.
  - Go to RUN.
  - A start held for multiple cycles restarts only once, because it is ignored in RUN.
- RUN:
  - cpu_run=1.
  - cycle_count increments by 1 each cycle and saturates at all-ones.
  - Stop condition A: max_cycles!=0 and cycle_count+1==max_cycles. The budget is therefore exactly max_cycles RUN cycles.
  - Stop condition B: halt_pc_en and pc==halt_pc. The compare is on the current-cycle pc, bit-exact.
  - On a stop, latch halt_cause (both conditions gives 11) and go to DRAIN.
  - max_cycles=0 with halt_pc_en=0 runs indefinitely until rst.
- DRAIN:
  - cpu_run=1 for exactly DRAIN_CYCLES cycles.
  - cycle_count frozen.
  - Then go to CHECK.
  - DRAIN_CYCLES=0 goes directly to CHECK.
- CHECK:
  - cpu_run=0.
  - Walk idx 0..NUM_CHECKS-1 in order; skip invalid entries at 1 cycle each.
  - For each valid entry, issue rf_rd_addr=entry.reg, then compare rf_rd_data with entry.val on the next cycle. Cost is 2 cycles per entry.
  - Equality is full-width and bit-exact, so negative values are compared as two's complement.
  - On a mismatch, increment fail_count. On the first mismatch only, latch first_fail_idx and first_fail_data.
  - After the last idx, go to DONE.
  - An empty table reaches DONE with pass=1.
- DONE:
  - done=1; pass is valid; all results held until the next start or rst.
- Table writes:
  - A write in IDLE/DONE sets the entry's valid bit.
  - exp_clr takes priority over exp_wr_en in the same cycle.
  - Writes during busy are dropped silently.
- rf_rd_addr holds its last value outside CHECK.

Test Plan:
- Budget stop:
  - Stimulus: max_cycles=10, halt_pc_en=0; table {19:5, 20:10, 21:3, 22:2, 23:15, 24:32'hFFFFFFFE}; model returns those values.
  - Required: cpu_run high for 10+5 cycles; cycle_count=10; halt_cause=01; pass=1; fail_count=0.
- PC stop:
  - Stimulus: max_cycles=0, halt_pc_en=1, halt_pc=200; pc reaches 200 on RUN cycle 7.
  - Required: cycle_count=7; halt_cause=10.
- Simultaneous stop:
  - Stimulus: budget expiry and PC match in the same cycle.
  - Required: halt_cause=11.
- Mismatches:
  - Stimulus: register 21 reads 4 and register 24 reads 2.
  - Required: fail_count=2; first_fail_idx=2; first_fail_data=4; pass=0.
- Empty table and sparse table:
  - Stimulus: exp_clr then start; separately, only idx 5 valid.
  - Required: empty table reaches DONE with pass=1. Sparse table takes exactly NUM_CHECKS+1 cycles in CHECK.
- Reset and ignored inputs:
  - Stimulus: rst asserted mid-DRAIN; exp_wr_en and start pulses during RUN.
  - Required: rst gives IDLE and all outputs 0 the next cycle. The pulses during RUN do not alter the table or restart the run.
